// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : gate_sweep_ctrl
//  Purpose  : Drives a 2-input gate box through the four input vectors
//             (a,b)=00,01,10,11, holds each for DWELL cycles, then samples
//             the six gate outputs against their ideal truth table.
//             Reports pass/fail, a sticky per-output error mask and the
//             first failing step.
//  Option   : GATE_SWEEP_LOG_EN - adds a 4x6 capture log of the sampled
//             gate_y values, readable through log_idx/log_data.
//  Revision : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl #(
   parameter int unsigned DWELL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       gate_a,
   output logic       gate_b,
   input  logic [5:0] gate_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] err_mask,
   output logic [1:0] fail_step,
   input  logic [1:0] log_idx,
   output logic [5:0] log_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] DWELL_RELOAD = 4'(DWELL - 1);

   state_t     state_q;
   logic [1:0] step_q;
   logic [3:0] cnt_q;
   logic       gate_a_q;
   logic       gate_b_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [5:0] err_mask_q;
   logic [1:0] fail_step_q;

   logic [5:0] expect_y;
   logic [5:0] mismatch;
   logic [5:0] err_next;
   logic [1:0] step_inc;
   logic       start_ok;

   // Ideal gate box response for the vector currently driven (step = {a,b})
   always_comb begin
      expect_y = {~(step_q[1] ^ step_q[0]),
                    step_q[1] ^ step_q[0],
                  ~(step_q[1] | step_q[0]),
                  ~(step_q[1] & step_q[0]),
                    step_q[1] | step_q[0],
                    step_q[1] & step_q[0]};
      mismatch = expect_y ^ gate_y;
      err_next = err_mask_q | mismatch;
      step_inc = step_q + 2'd1;
      start_ok = (state_q == S_IDLE) && start && !abort;
   end

   // Sweep sequencer with registered outputs; abort returns to IDLE holding partial results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_q      <= 2'd0;
         cnt_q       <= 4'd0;
         gate_a_q    <= 1'b0;
         gate_b_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_mask_q  <= 6'd0;
         fail_step_q <= 2'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  state_q     <= S_DRIVE;
                  step_q      <= 2'd0;
                  cnt_q       <= DWELL_RELOAD;
                  gate_a_q    <= 1'b0;
                  gate_b_q    <= 1'b0;
                  busy_q      <= 1'b1;
                  pass_q      <= 1'b0;
                  err_mask_q  <= 6'd0;
                  fail_step_q <= 2'd0;
               end
            end
            S_DRIVE: begin
               if (abort) begin
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  gate_a_q <= 1'b0;
                  gate_b_q <= 1'b0;
               end else if (cnt_q == 4'd0) begin
                  state_q <= S_SAMPLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_SAMPLE: begin
               if (abort) begin
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  gate_a_q <= 1'b0;
                  gate_b_q <= 1'b0;
               end else begin
                  err_mask_q <= err_next;
                  // Only the first failing step is recorded
                  if ((err_mask_q == 6'd0) && (mismatch != 6'd0)) begin
                     fail_step_q <= step_q;
                  end
                  if (step_q == 2'd3) begin
                     state_q  <= S_DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     pass_q   <= (err_next == 6'd0);
                     gate_a_q <= 1'b0;
                     gate_b_q <= 1'b0;
                  end else begin
                     state_q  <= S_DRIVE;
                     step_q   <= step_inc;
                     cnt_q    <= DWELL_RELOAD;
                     gate_a_q <= step_inc[1];
                     gate_b_q <= step_inc[0];
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign gate_a    = gate_a_q;
   assign gate_b    = gate_b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_mask  = err_mask_q;
   assign fail_step = fail_step_q;

`ifdef GATE_SWEEP_LOG_EN
   logic [5:0] log_q [4];

   // Capture log: cleared on reset and accepted start, written at each completed sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) log_q[i] <= 6'd0;
      end else if (start_ok) begin
         for (int i = 0; i < 4; i++) log_q[i] <= 6'd0;
      end else if ((state_q == S_SAMPLE) && !abort) begin
         log_q[step_q] <= gate_y;
      end
   end

   assign log_data = log_q[log_idx];
`else
   logic unused_log_idx;

   assign unused_log_idx = ^log_idx;
   assign log_data       = 6'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_gate_sweep_ctrl
//  Purpose  : Scoreboard bench for gate_sweep_ctrl with a faultable gate box.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

   localparam int DWELL     = 2;
   localparam int STEP_LEN  = DWELL + 1;
   localparam int SWEEP_LEN = 4 * STEP_LEN;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       gate_a, gate_b, busy, done, pass;
   logic [5:0] gate_y, err_mask, log_data;
   logic [1:0] fail_step;
   logic [1:0] log_idx = 2'd0;

   logic [5:0] fmask = 6'd0;
   logic [5:0] fval  = 6'd0;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         aborted;
      bit         pass;
      logic [5:0] err;
      logic [1:0] fs;
      int         start_cyc;
      int         end_cyc;
   } exp_t;

   exp_t sb[$];

   bit         last_pass = 1'b0;
   logic [5:0] last_err  = 6'd0;
   logic [1:0] last_fs   = 2'd0;
   logic [5:0] logm [4];

   gate_sweep_ctrl #(.DWELL(DWELL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .gate_a    (gate_a),
      .gate_b    (gate_b),
      .gate_y    (gate_y),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_mask  (err_mask),
      .fail_step (fail_step),
      .log_idx   (log_idx),
      .log_data  (log_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Truth table of the six gates for input vector s = 2*a + b
   function automatic logic [5:0] truth(int s);
      int a, b;
      logic [5:0] v;
      a = s / 2;
      b = s % 2;
      v[0] = ((a * b) == 1);
      v[1] = ((a + b) > 0);
      v[2] = ((a * b) == 0);
      v[3] = ((a + b) == 0);
      v[4] = ((a + b) == 1);
      v[5] = ((a + b) != 1);
      return v;
   endfunction

   function automatic logic [5:0] faulty(int s);
      return (truth(s) & ~fmask) | (fval & fmask);
   endfunction

   always_comb begin
      gate_y = (truth(int'({gate_a, gate_b})) & ~fmask) | (fval & fmask);
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: tracks the drive pattern and pops the scoreboard whenever a sweep ends
   bit prev_busy = 1'b0;
   int rise      = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy = 1'b0;
      end else begin
         if (busy && !prev_busy) rise = cyc;
         if (busy) chk("drive_vector", {30'd0, gate_a, gate_b}, 32'((cyc - rise) / STEP_LEN));
         else      chk("gates_idle", {30'd0, gate_a, gate_b}, 32'd0);
         if (prev_busy && !busy) begin
            if (sb.size() == 0) begin
               chk("busy_fall_without_sweep", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("start_edge", rise, e.start_cyc);
               chk("end_edge", cyc, e.end_cyc);
               chk("done_pulse", {31'd0, done}, {31'd0, !e.aborted});
               chk("pass", {31'd0, pass}, {31'd0, e.pass});
               chk("err_mask", {26'd0, err_mask}, {26'd0, e.err});
               chk("fail_step", {30'd0, fail_step}, {30'd0, e.fs});
            end
         end else if (done) begin
            chk("unexpected_done", 1, 0);
         end
         prev_busy = busy;
      end
   end

   task automatic wait_until(int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic check_held();
      chk("hold_pass", {31'd0, pass}, {31'd0, last_pass});
      chk("hold_err_mask", {26'd0, err_mask}, {26'd0, last_err});
      chk("hold_fail_step", {30'd0, fail_step}, {30'd0, last_fs});
      for (int i = 0; i < 4; i++) begin
         log_idx = 2'(i);
         #1;
`ifdef GATE_SWEEP_LOG_EN
         chk("log_data", {26'd0, log_data}, {26'd0, logm[i]});
`else
         chk("log_data_tied", {26'd0, log_data}, 32'd0);
`endif
      end
      @(negedge clk);
   endtask

   // kind: 0 normal, 1 extra start mid-sweep, 2 abort, 3 reset mid-sweep
   task automatic sweep(int kind, bit rnd, logic [5:0] fm, logic [5:0] fv, int kf);
      int s, k, nsamp;
      logic [5:0] err, d;
      logic [1:0] fs;
      bit found;
      exp_t e;
      if (rnd) begin
         case ($urandom_range(0, 2))
            0: begin fmask = 6'd0; fval = 6'd0; end
            1: begin fmask = 6'(1 << $urandom_range(0, 5)); fval = 6'($urandom); end
            default: begin fmask = 6'($urandom); fval = 6'($urandom); end
         endcase
      end else begin
         fmask = fm;
         fval  = fv;
      end
      k = kf;
      if (k == 0 && kind == 2) k = $urandom_range(1, SWEEP_LEN);
      if (k == 0 && kind == 3) k = $urandom_range(1, SWEEP_LEN - 1);
      nsamp = 4;
      if (kind == 2) begin
         nsamp = 0;
         for (int j = 0; j < 4; j++) if (STEP_LEN * (j + 1) < k) nsamp = j + 1;
      end
      err = 6'd0; fs = 2'd0; found = 1'b0;
      for (int j = 0; j < 4; j++) logm[j] = 6'd0;
      for (int j = 0; j < nsamp; j++) begin
         logm[j] = faulty(j);
         d = logm[j] ^ truth(j);
         if (d != 6'd0 && !found) begin fs = 2'(j); found = 1'b1; end
         err = err | d;
      end
      s = cyc + 1;
      e.aborted   = (kind == 2);
      e.pass      = (kind != 2) && (err == 6'd0);
      e.err       = err;
      e.fs        = fs;
      e.start_cyc = s;
      e.end_cyc   = s + ((kind == 2) ? k : SWEEP_LEN);
      if (kind != 3) sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (kind == 1) begin
         wait_until(s + 4);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      if (kind == 2) begin
         wait_until(s + k - 1);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      if (kind == 3) begin
         wait_until(s + k - 1);
         #2 rst_n = 1'b0;
         sb.delete();
         #1;
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_gates", {30'd0, gate_a, gate_b}, 32'd0);
         chk("rst_err_mask", {26'd0, err_mask}, 32'd0);
         chk("rst_flags", {29'd0, done, pass, |fail_step}, 32'd0);
         chk("rst_log", {26'd0, log_data}, 32'd0);
         @(negedge clk);
         @(negedge clk);
         #2 rst_n = 1'b1;
         @(negedge clk);
         last_pass = 1'b0;
         last_err  = 6'd0;
         last_fs   = 2'd0;
         for (int j = 0; j < 4; j++) logm[j] = 6'd0;
      end else begin
         for (int t = 0; t < SWEEP_LEN + 10 && sb.size() != 0; t++) @(negedge clk);
         if (sb.size() != 0) begin
            chk("sweep_timeout", sb.size(), 0);
            sb.delete();
         end
         last_pass = e.pass;
         last_err  = e.err;
         last_fs   = e.fs;
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      check_held();
   endtask

   // start together with abort in IDLE must be ignored
   task automatic start_abort_idle();
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_abort_busy", {31'd0, busy}, 32'd0);
      check_held();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_gates", {30'd0, gate_a, gate_b}, 32'd0);
      chk("reset_done_pass", {30'd0, done, pass}, 32'd0);
      chk("reset_err_mask", {26'd0, err_mask}, 32'd0);
      chk("reset_fail_step", {30'd0, fail_step}, 32'd0);
      chk("reset_log", {26'd0, log_data}, 32'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      sweep(0, 1'b0, 6'd0, 6'd0, 0);             // good gate box
      sweep(0, 1'b0, 6'b010000, 6'd0, 0);        // xr stuck at 0
      sweep(1, 1'b0, 6'd0, 6'd0, 0);             // second start at edge 5
      sweep(2, 1'b0, 6'd0, 6'd0, 5);             // abort at edge 5
      sweep(0, 1'b0, 6'd0, 6'd0, 0);             // recovers after abort
      sweep(2, 1'b0, 6'b000001, 6'b000001, 12);  // abort on the final sample
      sweep(3, 1'b0, 6'd0, 6'd0, 7);             // reset mid-sweep
      start_abort_idle();

      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom_range(0, 4);
         if (kind == 4) start_abort_idle();
         else           sweep(kind, 1'b1, 6'd0, 6'd0, 0);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
